// File: rtl/apb_rr_master_if.sv
// APB bus between the round-robin master and the two-slave fabric.
// prdata/pready/pslverr arrive already muxed from the selected slave.
interface apb_rr_master_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [7:0]        paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin arbitrated APB master: NREQ requesters share one APB bus to two
// 256-byte slaves, with a bounded ACCESS phase and per-owner response pulses.
module apb_rr_master #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*9-1:0]        req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  apb_rr_master_if.master          bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [CW-1:0]     cnt;
  logic              do_grant;
  logic [8:0]        addr_a  [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[9*i +: 9];
    assign wdata_a[i] = req_wdata[DATA_W*i +: DATA_W];
  end

  // Scan from ptr+NREQ down to ptr+1 so the nearest requester after ptr wins.
  always_comb begin
    int pos;
    pos = 0;
    win = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req_valid[PW'(pos)]) win = PW'(pos);
    end
  end

  // Grants happen from IDLE or at a clean completion; never on abort.
  assign do_grant = (|req_valid) &&
                    ((state == IDLE) || ((state == ACCESS) && bus.pready));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      ptr         <= PW'(NREQ-1);
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      bus.psel    <= '0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.paddr   <= '0;
      bus.pwdata  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: ;
        SETUP: begin
          bus.penable <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            rsp_valid[ptr] <= 1'b1;
            rsp_err        <= bus.pslverr;
            rsp_rdata      <= bus.pwrite ? '0 : bus.prdata;
            state          <= IDLE;
            bus.psel       <= '0;
            bus.penable    <= 1'b0;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            rsp_valid[ptr] <= 1'b1;
            rsp_err        <= 1'b1;
            rsp_rdata      <= '0;
            state          <= IDLE;
            bus.psel       <= '0;
            bus.penable    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // ptr doubles as the owner of the in-flight transfer.
      if (do_grant) begin
        state          <= SETUP;
        ptr            <= win;
        req_ready[win] <= 1'b1;
        bus.psel       <= addr_a[win][8] ? 2'b10 : 2'b01;
        bus.penable    <= 1'b0;
        bus.pwrite     <= req_write[win];
        bus.paddr      <= addr_a[win][7:0];
        bus.pwdata     <= req_write[win] ? wdata_a[win] : '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios plus a randomized phase, all
// checked against a transaction-level model of arbitration and slave timing.
module tb_apb_rr_master;
  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int TO   = 16;

  typedef struct packed {
    logic          wr;
    logic [8:0]    addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic                 pclk = 1'b0;
  logic                 presetn = 1'b0;
  logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*9-1:0]    req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;

  apb_rr_master_if #(.DATA_W(DW)) bus ();

  apb_rr_master #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus(bus)
  );

  always #5 pclk = ~pclk;

  int checks = 0, errors = 0, cyc = 0;
  cmd_t q[NREQ][$];
  cmd_t pres[NREQ];
  int   p_assert = 100;
  int   force_w = -1, force_err = -1, force_rd = -1;
  int   acc = 0, x_w = 0;
  bit   x_err = 1'b0;
  logic [DW-1:0] x_rd = '0;
  int   ptr_m = NREQ-1, owner_m = 0, acc_seen = 0, since_gnt = 0;
  bit   busy = 1'b0;
  cmd_t cmd_m;
  int   gnt_log[$];
  int   ready_cyc = 0, rsp_cyc = 0;
  logic last_err = 1'b0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(logic wr, logic [8:0] a, logic [DW-1:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic logic [1:0] exp_sel(cmd_t c);
    return c.addr[8] ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [DW-1:0] exp_wd(cmd_t c);
    return c.wr ? c.wdata : '0;
  endfunction

  // First valid requester after p, wrapping.
  function automatic int rr_pick(int p, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic bit pending();
    bit r;
    r = (req_valid != '0);
    for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic monitor(logic [NREQ-1:0] v);
    bit was_busy, to, exp_g;
    int e;
    was_busy = busy;
    exp_g    = 1'b0;
    to       = (x_w >= TO);
    if (busy && bus.penable) begin
      acc_seen++;
      chk("access_hold", 64'({bus.psel, bus.pwrite, bus.paddr, bus.pwdata}),
          64'({exp_sel(cmd_m), cmd_m.wr, cmd_m.addr[7:0], exp_wd(cmd_m)}));
    end
    if (rsp_valid != '0) begin
      chk("rsp_owner", 64'(rsp_valid), was_busy ? (64'(1) << owner_m) : 64'(0));
      chk("rsp_err", 64'(rsp_err), 64'(to ? 1'b1 : x_err));
      chk("rsp_rdata", 64'(rsp_rdata), (to || cmd_m.wr) ? 64'(0) : 64'(x_rd));
      chk("access_len", 64'(acc_seen), 64'(to ? TO : x_w + 1));
      last_err = rsp_err;
      rsp_cyc  = cyc;
      busy     = 1'b0;
      exp_g    = !to && (v != '0);
    end else if (was_busy) begin
      since_gnt++;
      if (since_gnt > TO + 3) begin
        chk("rsp_missing", 64'(rsp_valid), 64'(1) << owner_m);
        busy = 1'b0;
      end
    end else begin
      exp_g = (v != '0);
    end
    chk("grant_any", 64'(req_ready != '0), 64'(exp_g));
    if (exp_g) begin
      e = rr_pick(ptr_m, v);
      chk("grant_who", 64'(req_ready), 64'(1) << e);
      ptr_m = e; owner_m = e; cmd_m = pres[e];
      busy = 1'b1; acc_seen = 0; since_gnt = 0; ready_cyc = cyc;
      gnt_log.push_back(e);
      chk("setup_bus", 64'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}),
          64'({exp_sel(cmd_m), 1'b0, cmd_m.wr, cmd_m.addr[7:0], exp_wd(cmd_m)}));
    end else if (!busy) begin
      chk("idle_bus", 64'({bus.psel, bus.penable}), 64'(0));
    end
  endtask

  // Slave: pready rises after x_w low ACCESS cycles; x_w >= TO never answers.
  task automatic responder();
    if (bus.penable && presetn) acc++; else acc = 0;
    if (acc == 1) begin
      x_w   = (force_w >= 0) ? force_w :
              (($urandom % 8 == 0) ? TO + 2 : int'($urandom_range(0, 3)));
      x_err = (force_err >= 0) ? force_err[0] : ($urandom % 4 == 0);
      x_rd  = (force_rd >= 0) ? force_rd[DW-1:0] : DW'($urandom);
      bus.prdata  = x_rd;
      bus.pslverr = x_err;
    end
    bus.pready = (acc > x_w);
  endtask

  task automatic requesters();
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        void'(q[i].pop_front());
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && q[i].size() > 0 && $urandom_range(0, 99) < p_assert) begin
        pres[i]      = q[i][0];
        req_valid[i] = 1'b1;
      end
      req_write[i]          = pres[i].wr;
      req_addr[9*i +: 9]    = pres[i].addr;
      req_wdata[DW*i +: DW] = pres[i].wdata;
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] v;
    @(negedge pclk);
    cyc++;
    v = req_valid;
    if (presetn) monitor(v);
    else chk("quiet_in_reset", 64'({req_ready, rsp_valid, bus.psel, bus.penable}), 64'(0));
    responder();
    requesters();
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((pending() || busy) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 64'(pending() || busy), 64'(0));
    step();
  endtask

  initial begin
    int c0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    for (int i = 0; i < NREQ; i++) pres[i] = '0;
    cmd_m = '0;

    #12;
    chk("reset_outs", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, bus.psel,
        bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 64'(0));
    #1 presetn = 1'b1;
    step();

    // single write, zero wait states
    force_w = 0; force_err = 0; force_rd = 8'h77;
    q[0].push_back(mk(1'b1, 9'h012, 8'hA5));
    step();
    c0 = cyc;
    drain(50);
    chk("t1_ready_lat", 64'(ready_cyc - c0), 64'(1));
    chk("t1_rsp_lat", 64'(rsp_cyc - ready_cyc), 64'(2));

    // read from slave 2 with three wait states
    force_w = 3; force_rd = 8'h3C;
    q[1].push_back(mk(1'b0, 9'h1F0, 8'h00));
    drain(50);
    chk("t2_grant", 64'(gnt_log[$]), 64'(1));

    // contention between req0 and req1, back-to-back
    force_w = 1; force_rd = -1;
    gnt_log.delete();
    for (int k = 0; k < 2; k++) begin
      q[0].push_back(mk(1'($urandom), 9'($urandom), DW'($urandom)));
      q[1].push_back(mk(1'($urandom), 9'($urandom), DW'($urandom)));
    end
    drain(100);
    chk("t3_count", 64'(gnt_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      chk("t3_order", 64'(gnt_log[k]), 64'(k % 2));

    // slave error then clean transfer
    force_w = 0; force_err = 1;
    q[2].push_back(mk(1'b1, 9'h055, 8'h5A));
    drain(50);
    chk("t4_err_set", 64'(last_err), 64'(1));
    force_err = 0;
    q[2].push_back(mk(1'b1, 9'h056, 8'h5B));
    drain(50);
    chk("t4_err_clear", 64'(last_err), 64'(0));

    // last cycle before timeout still completes; then real timeouts
    force_w = TO - 1; force_rd = 8'hC3;
    q[0].push_back(mk(1'b0, 9'h0AA, 8'h00));
    drain(60);
    chk("t5_edge_ok", 64'(last_err), 64'(0));
    force_w = 100;
    q[0].push_back(mk(1'b0, 9'h1AA, 8'h00));
    q[1].push_back(mk(1'b1, 9'h0BB, 8'h11));
    drain(120);
    chk("t5_timeout_err", 64'(last_err), 64'(1));

    // reset in the middle of ACCESS
    q[1].push_back(mk(1'b0, 9'h123, 8'h00));
    for (int n = 0; n < 8 && !(busy && bus.penable); n++) step();
    chk("t6_in_access", 64'(bus.penable), 64'(1));
    step(); step();
    #2 presetn = 1'b0;
    #1 chk("t6_reset_outs", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, bus.psel,
           bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 64'(0));
    busy = 1'b0; ptr_m = NREQ - 1; acc = 0; bus.pready = 1'b0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    req_valid = '0;
    step(); step();
    #2 presetn = 1'b1;
    force_w = 0;
    gnt_log.delete();
    q[1].push_back(mk(1'b1, 9'h101, 8'h01));
    q[0].push_back(mk(1'b1, 9'h002, 8'h02));
    drain(50);
    chk("t6_req0_first", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'(0));

    // randomized traffic from all requesters
    force_w = -1; force_err = -1; force_rd = -1; p_assert = 60;
    for (int n = 0; n < 60; n++)
      q[$urandom_range(0, NREQ-1)].push_back(mk(1'($urandom), 9'($urandom), DW'($urandom)));
    drain(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
